// File: rtl/log_pkg.sv
// ---------------------------------------------------------------------------
// log_pkg
// Shared constants and types for the log-compression path. Used by
// log_normalize, log_frac_calc and the downstream combiner.
//   DATA_WIDTH  : envelope sample width (unsigned)
//   FRAC_WIDTH  : mantissa fraction bits
//   NORM_WIDTH  : mantissa width (1 integer bit + FRAC_WIDTH fraction bits)
//   EXP_WIDTH   : exponent width, also the number of leading-one search steps
//   SCAN_WIDTH  : width of the power-of-two search window
//   ONE         : mantissa value 1.0
//   state_t     : normaliser FSM encoding
// ---------------------------------------------------------------------------
package log_pkg;

   localparam int DATA_WIDTH = 48;
   localparam int FRAC_WIDTH = 16;
   localparam int NORM_WIDTH = FRAC_WIDTH + 1;
   localparam int EXP_WIDTH  = $clog2(DATA_WIDTH);
   localparam int SCAN_WIDTH = 2 ** EXP_WIDTH;

   localparam logic [NORM_WIDTH-1:0] ONE     = {1'b1, {FRAC_WIDTH{1'b0}}};
   localparam logic [EXP_WIDTH-1:0]  MSB_IDX = EXP_WIDTH'(DATA_WIDTH - 1);
   localparam logic [EXP_WIDTH:0]    SH_ONE  = {{EXP_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Shift amount of search step k: 2^k.
   function automatic logic [EXP_WIDTH:0] step_shift(input logic [EXP_WIDTH-1:0] k);
      step_shift = SH_ONE << k;
   endfunction

   // Mask selecting the top 2^k bits of the search window.
   function automatic logic [SCAN_WIDTH-1:0] top_mask(input logic [EXP_WIDTH-1:0] k);
      top_mask = ~({SCAN_WIDTH{1'b1}} >> step_shift(k));
   endfunction

endpackage

// File: rtl/log_normalize.sv
// ---------------------------------------------------------------------------
// log_normalize
// Leading-one normaliser for the log-compression front end. Computes
// floor(log2(data_in)) and the mantissa data_in / 2^exp in 1.FRAC_WIDTH
// format, using a binary search (one halving step per clock). Result
// appears EXP_WIDTH clocks after the accept edge.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   data_in valid
//   in_ready   out  block is idle and can accept a sample
//   data_in    in   unsigned sample, DATA_WIDTH bits
//   out_valid  out  exp_out / norm_out / zero_out valid
//   out_ready  in   downstream accepts the result
//   exp_out    out  MSB position of the sample
//   norm_out   out  normalised mantissa, truncated
//   zero_out   out  sample was zero
// ---------------------------------------------------------------------------
module log_normalize
   import log_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_WIDTH-1:0]  exp_out,
   output logic [NORM_WIDTH-1:0] norm_out,
   output logic                  zero_out
);

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [SCAN_WIDTH-1:0]   w_r;
   logic [SCAN_WIDTH-1:0]   w_nxt_s;
   logic [EXP_WIDTH-1:0]    lz_r;
   logic [EXP_WIDTH-1:0]    lz_nxt_s;
   logic [EXP_WIDTH-1:0]    step_r;
   logic                    zflag_r;
   logic [EXP_WIDTH:0]      shamt_s;
   logic                    hit_s;
   logic                    accept_s;
   logic                    last_step_s;

   assign in_ready    = (state_r == IDLE);
   assign accept_s    = in_valid && (state_r == IDLE);
   assign last_step_s = (state_r == SCAN) && (step_r == {EXP_WIDTH{1'b0}});

   // One binary-search step: if the top 2^k bits are empty, shift them out.
   always_comb begin
      shamt_s  = step_shift(step_r);
      hit_s    = ((w_r & top_mask(step_r)) == {SCAN_WIDTH{1'b0}});
      w_nxt_s  = w_r;
      lz_nxt_s = lz_r;
      if (hit_s) begin
         w_nxt_s  = w_r << shamt_s;
         // 2^k never exceeds 2^(EXP_WIDTH-1), so the top bit of shamt_s is always 0 here.
         lz_nxt_s = lz_r + shamt_s[EXP_WIDTH-1:0];
      end else begin
         w_nxt_s  = w_r;
         lz_nxt_s = lz_r;
      end
   end

   // Next-state logic for IDLE -> SCAN -> DONE -> IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = SCAN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SCAN: begin
            if (last_step_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = SCAN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Search datapath: load on accept, step while scanning.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_r     <= {SCAN_WIDTH{1'b0}};
         lz_r    <= {EXP_WIDTH{1'b0}};
         step_r  <= {EXP_WIDTH{1'b0}};
         zflag_r <= 1'b0;
      end else if (accept_s) begin
         // Zero padding at the LSB end lets the window be a power of two.
         w_r     <= {data_in, {(SCAN_WIDTH-DATA_WIDTH){1'b0}}};
         lz_r    <= {EXP_WIDTH{1'b0}};
         step_r  <= EXP_WIDTH'(EXP_WIDTH - 1);
         zflag_r <= (data_in == {DATA_WIDTH{1'b0}});
      end else if (state_r == SCAN) begin
         w_r    <= w_nxt_s;
         lz_r   <= lz_nxt_s;
         if (!last_step_s) begin
            step_r <= step_r - {{(EXP_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   // Output registers: loaded from the final step, held until the next result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         exp_out   <= {EXP_WIDTH{1'b0}};
         norm_out  <= {NORM_WIDTH{1'b0}};
         zero_out  <= 1'b0;
      end else if (last_step_s) begin
         out_valid <= 1'b1;
         zero_out  <= zflag_r;
         if (zflag_r) begin
            // lz has run to all-ones for a zero sample and carries no meaning.
            exp_out  <= {EXP_WIDTH{1'b0}};
            norm_out <= ONE;
         end else begin
            exp_out  <= MSB_IDX - lz_nxt_s;
            norm_out <= w_nxt_s[SCAN_WIDTH-1 -: NORM_WIDTH];
         end
      end else if ((state_r == DONE) && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_log_normalize.sv
// ---------------------------------------------------------------------------
// tb_log_normalize
// Self-checking bench for log_normalize: directed vector table, stall and
// mid-scan reset sequences, and random samples against a bit-loop model.
// ---------------------------------------------------------------------------
module tb_log_normalize;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  exp_out;
   logic [16:0] norm_out;
   logic        zero_out;

   int tests;
   int fails;

   typedef struct {
      logic [47:0] x;
      logic [5:0]  e;
      logic [16:0] n;
      logic        z;
   } vec_t;

   vec_t vecs[10];

   log_normalize dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .exp_out   (exp_out),
      .norm_out  (norm_out),
      .zero_out  (zero_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent model: scan bits for the highest one.
   function automatic logic [5:0] ref_exp(input logic [47:0] x);
      logic [5:0] r;
      r = 6'd0;
      for (int i = 0; i < 48; i++) begin
         if (x[i]) r = 6'(i);
      end
      return r;
   endfunction

   function automatic logic [16:0] ref_norm(input logic [47:0] x);
      logic [63:0] t;
      int e;
      if (x == 48'd0) return 17'h10000;
      e = int'(ref_exp(x));
      if (e >= 16) t = {16'd0, x} >> (e - 16);
      else         t = {16'd0, x} << (16 - e);
      return t[16:0];
   endfunction

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
   endtask

   // Full transaction with out_ready high; checks latency, outputs and release.
   task automatic do_sample(input logic [47:0] x, input logic [5:0] e,
                            input logic [16:0] n, input logic z, input string tag);
      wait_ready(tag);
      in_valid = 1'b1;
      data_in  = x;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 5) check({tag, "_lat5"}, {63'd0, out_valid}, 64'd0);
      end
      check({tag, "_lat6"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_exp"},  {58'd0, exp_out},  {58'd0, e});
      check({tag, "_norm"}, {47'd0, norm_out}, {47'd0, n});
      check({tag, "_zero"}, {63'd0, zero_out}, {63'd0, z});
      tick();
      check({tag, "_release"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      logic [47:0] hold_e_n;
      logic [63:0] r64;
      logic [47:0] x;

      tests     = 0;
      fails     = 0;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      data_in   = 48'd0;

      vecs[0] = '{48'h1,            6'd0,  17'h10000, 1'b0};
      vecs[1] = '{48'h3,            6'd1,  17'h18000, 1'b0};
      vecs[2] = '{48'h800000000000, 6'd47, 17'h10000, 1'b0};
      vecs[3] = '{48'hFFFFFFFFFFFF, 6'd47, 17'h1FFFF, 1'b0};
      vecs[4] = '{48'h0,            6'd0,  17'h10000, 1'b1};
      vecs[5] = '{48'h12345,        6'd16, 17'h12345, 1'b0};
      vecs[6] = '{48'h10000,        6'd16, 17'h10000, 1'b0};
      vecs[7] = '{48'hFFFF,         6'd15, 17'h1FFFE, 1'b0};
      vecs[8] = '{48'h80000000,     6'd31, 17'h10000, 1'b0};
      vecs[9] = '{48'h5,            6'd2,  17'h14000, 1'b0};

      repeat (3) tick();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_exp",       {58'd0, exp_out},   64'd0);
      check("rst_norm",      {47'd0, norm_out},  64'd0);
      check("rst_zero",      {63'd0, zero_out},  64'd0);
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         do_sample(vecs[i].x, vecs[i].e, vecs[i].n, vecs[i].z, $sformatf("vec%0d", i));
      end

      // Stall in DONE with in_valid pulses that must be ignored.
      out_ready = 1'b0;
      wait_ready("stall");
      in_valid = 1'b1;
      data_in  = 48'h3;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      hold_e_n = {25'd0, exp_out, norm_out};
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         data_in  = 48'hFFFFFFFFFFFF;
         tick();
         check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
         check("stall_hold_data", {16'd0, 25'd0, exp_out, norm_out}, {16'd0, hold_e_n});
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      check("stall_exp",  {58'd0, exp_out},  64'd1);
      check("stall_norm", {47'd0, norm_out}, 64'h18000);
      out_ready = 1'b1;
      tick();
      check("stall_release", {63'd0, out_valid}, 64'd0);
      check("stall_idle",    {63'd0, in_ready},  64'd1);
      do_sample(48'h5, 6'd2, 17'h14000, 1'b0, "after_stall");

      // Reset in the middle of the search aborts the sample.
      wait_ready("rst_mid");
      in_valid = 1'b1;
      data_in  = 48'h800000000000;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("rst_mid_busy", {63'd0, in_ready}, 64'd0);
      reset_n = 1'b0;
      #1;
      check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
      check("rst_mid_ready", {63'd0, in_ready},  64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("rst_mid_stale", {63'd0, out_valid}, 64'd0);
      end
      do_sample(48'h3, 6'd1, 17'h18000, 1'b0, "after_rst");

      // Random samples spread over all magnitudes.
      for (int i = 0; i < 1200; i++) begin
         r64 = {$urandom, $urandom};
         x   = r64[47:0] >> $urandom_range(0, 47);
         if ($urandom_range(0, 99) == 0) x = 48'd0;
         do_sample(x, (x == 48'd0) ? 6'd0 : ref_exp(x), ref_norm(x),
                   (x == 48'd0), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
